// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared scene codes, FSM states, fade constants and RGB565 fields
package scene_pkg;

    // Full-brightness fade level; levels span 0..FADE_FULL.
    localparam int FADE_FULL = 16;

    // Scene codes. The scene value also selects the picture in the ROM reader.
    typedef enum logic [1:0] {
        SCN_TITLE = 2'd0,
        SCN_PLAY  = 2'd1,
        SCN_OVER  = 2'd2,
        SCN_WON   = 2'd3
    } scene_t;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        S_TITLE    = 3'd0,
        S_FADE_OUT = 3'd1,
        S_FADE_IN  = 3'd2,
        S_PLAY     = 3'd3,
        S_END      = 3'd4
    } state_t;

    // RGB565 field positions.
    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

endpackage

// File: rtl/scene_sequencer_fade.sv
// rtl/scene_sequencer_fade.sv - combinational brightness scaling of one RGB565 pixel
//
// Ports:
//   pix_in  [15:0] : RGB565 pixel
//   level   [4:0]  : brightness 0..16 (16 = unchanged, 0 = black)
//   pix_out [15:0] : each channel scaled as (ch * level) >> 4
module rgb565_fade
    import scene_pkg::*;
(
    input  logic [15:0] pix_in,
    input  logic [4:0]  level,
    output logic [15:0] pix_out
);

    logic [9:0]  r_prod;
    logic [10:0] g_prod;
    logic [9:0]  b_prod;

    assign r_prod = {5'd0, pix_in[R_MSB:R_LSB]} * {5'd0, level};
    assign g_prod = {5'd0, pix_in[G_MSB:G_LSB]} * {6'd0, level};
    assign b_prod = {5'd0, pix_in[B_MSB:B_LSB]} * {5'd0, level};

    // With level <= 16 each product shifted right by 4 never exceeds the input
    // channel, so the top product bit and the fractional bits are dropped.
    assign pix_out = {r_prod[8:4], g_prod[9:4], b_prod[8:4]};

    logic unused_prod_bits;
    assign unused_prod_bits = ^{r_prod[9], r_prod[3:0], g_prod[10], g_prod[3:0],
                                b_prod[9], b_prod[3:0]};

endmodule

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-synchronous scene FSM with fade-out/fade-in and source mux
//
// Ports:
//   vga_clk, sys_rst_n      : pixel clock, async active-low reset
//   vsync                   : active-low vertical sync from vga_ctrl
//   start                   : 1-cycle start/continue request
//   game_over, game_won     : level flags from game logic
//   rom_pix, game_pix       : RGB565 sources (presented one cycle early)
//   pix_data                : registered, faded RGB565 pixel
//   scene                   : current scene, also the ROM picture select
//   fade_level              : current brightness 0..16
//   game_rst                : 1-cycle game logic reset when play begins
//   busy                    : high during a fade
module scene_sequencer #(
    parameter int FADE_FRAMES = 2,
    parameter int FADE_FULL   = scene_pkg::FADE_FULL
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        vsync,
    input  logic        start,
    input  logic        game_over,
    input  logic        game_won,
    input  logic [15:0] rom_pix,
    input  logic [15:0] game_pix,
    output logic [15:0] pix_data,
    output logic [1:0]  scene,
    output logic [4:0]  fade_level,
    output logic        game_rst,
    output logic        busy
);

    import scene_pkg::*;

    localparam int              CW       = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CW-1:0]   FRM_LAST = CW'(FADE_FRAMES - 1);
    localparam logic [4:0]      LVL_FULL = 5'(FADE_FULL);

    state_t        state_q, state_d;
    state_t        dest_state_q, dest_state_d;
    scene_t        scene_q, scene_d;
    scene_t        dest_scene_q, dest_scene_d;
    logic [4:0]    fade_level_q, fade_level_d;
    logic [CW-1:0] frm_cnt_q, frm_cnt_d;
    logic          vs_d_q, vs_d_d;
    logic          start_pend_q, start_pend_d;
    logic          game_rst_q, game_rst_d;
    logic          busy_q, busy_d;
    logic [15:0]   pix_data_q, pix_data_d;

    logic          tick;
    logic [15:0]   src_pix;

    // Rising edge of vsync marks the end of the sync pulse, inside vertical blanking.
    assign tick = vsync & ~vs_d_q;

    assign src_pix = (scene_q == SCN_PLAY) ? game_pix : rom_pix;

    rgb565_fade u_fade (
        .pix_in  (src_pix),
        .level   (fade_level_q),
        .pix_out (pix_data_d)
    );

    always_comb begin
        state_d      = state_q;
        dest_state_d = dest_state_q;
        scene_d      = scene_q;
        dest_scene_d = dest_scene_q;
        fade_level_d = fade_level_q;
        frm_cnt_d    = frm_cnt_q;
        game_rst_d   = 1'b0;
        vs_d_d       = vsync;

        case (state_q)
            S_TITLE: begin
                if (tick && start_pend_q) begin
                    state_d      = S_FADE_OUT;
                    dest_state_d = S_PLAY;
                    dest_scene_d = SCN_PLAY;
                    frm_cnt_d    = '0;
                end
            end
            S_PLAY: begin
                // game_won wins when both flags are up on the same tick.
                if (tick && (game_won || game_over)) begin
                    state_d      = S_FADE_OUT;
                    dest_state_d = S_END;
                    dest_scene_d = game_won ? SCN_WON : SCN_OVER;
                    frm_cnt_d    = '0;
                end
            end
            S_END: begin
                if (tick && start_pend_q) begin
                    state_d      = S_FADE_OUT;
                    dest_state_d = S_TITLE;
                    dest_scene_d = SCN_TITLE;
                    frm_cnt_d    = '0;
                end
            end
            S_FADE_OUT: begin
                if (tick) begin
                    if (fade_level_q == 5'd0) begin
                        // Screen is black: switch picture/source, then fade back in.
                        scene_d    = dest_scene_q;
                        state_d    = S_FADE_IN;
                        frm_cnt_d  = '0;
                        game_rst_d = (dest_state_q == S_PLAY);
                    end else if (frm_cnt_q == FRM_LAST) begin
                        frm_cnt_d    = '0;
                        fade_level_d = fade_level_q - 5'd1;
                    end else begin
                        frm_cnt_d = frm_cnt_q + CW'(1);
                    end
                end
            end
            S_FADE_IN: begin
                if (tick) begin
                    if (fade_level_q >= LVL_FULL) begin
                        state_d = dest_state_q;
                    end else if (frm_cnt_q == FRM_LAST) begin
                        frm_cnt_d    = '0;
                        fade_level_d = fade_level_q + 5'd1;
                    end else begin
                        frm_cnt_d = frm_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_TITLE;
            end
        endcase

        // A start is only remembered on screens that wait for one; anywhere
        // else it is dropped so it cannot skip a later screen.
        if ((state_q != S_TITLE) && (state_q != S_END)) begin
            start_pend_d = 1'b0;
        end else if (tick && start_pend_q) begin
            start_pend_d = 1'b0;
        end else if (start) begin
            start_pend_d = 1'b1;
        end else begin
            start_pend_d = start_pend_q;
        end

        busy_d = (state_d == S_FADE_OUT) || (state_d == S_FADE_IN);
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_TITLE;
            dest_state_q <= S_TITLE;
            scene_q      <= SCN_TITLE;
            dest_scene_q <= SCN_TITLE;
            fade_level_q <= LVL_FULL;
            frm_cnt_q    <= '0;
            vs_d_q       <= 1'b0;
            start_pend_q <= 1'b0;
            game_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
            pix_data_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            dest_state_q <= dest_state_d;
            scene_q      <= scene_d;
            dest_scene_q <= dest_scene_d;
            fade_level_q <= fade_level_d;
            frm_cnt_q    <= frm_cnt_d;
            vs_d_q       <= vs_d_d;
            start_pend_q <= start_pend_d;
            game_rst_q   <= game_rst_d;
            busy_q       <= busy_d;
            pix_data_q   <= pix_data_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign scene      = scene_q;
    assign fade_level = fade_level_q;
    assign game_rst   = game_rst_q;
    assign busy       = busy_q;

endmodule
